// File: rtl/gpio_dflt_ctrl_pkg.sv
// Shared constants for the GPIO input-conditioning controller.
package gpio_dflt_ctrl_pkg;

  localparam int unsigned CNTW = 8;
  localparam logic [CNTW-1:0] DFLT_BYPASS = CNTW'(0);

endpackage

// File: rtl/gpio_dflt_ch.sv
// One GPIO input channel: 2-FF synchroniser, debounce filter, filtered output and edge pulses.
module gpio_dflt_ch
  import gpio_dflt_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pin,
  input  logic            smp_tick,
  input  logic [CNTW-1:0] dflt_st,
  output logic            gpio_in,
  output logic            rise_pls,
  output logic            fall_pls
);

  logic            sync_meta;
  logic            sync;
  logic [CNTW-1:0] dcnt;
  logic [CNTW-1:0] dcnt_nxt;
  logic            gpio_nxt;

  // Filter decision; the counter compare is widened so dcnt+1 never wraps.
  always_comb begin
    gpio_nxt = gpio_in;
    dcnt_nxt = dcnt;
    if (dflt_st == DFLT_BYPASS) begin
      gpio_nxt = sync;
      dcnt_nxt = '0;
    end else if (smp_tick) begin
      if (sync == gpio_in) begin
        dcnt_nxt = '0;
      end else if ((CNTW+1)'(dcnt) + (CNTW+1)'(1) >= (CNTW+1)'(dflt_st)) begin
        gpio_nxt = sync;
        dcnt_nxt = '0;
      end else begin
        dcnt_nxt = dcnt + CNTW'(1);
      end
    end
  end

  // Edge pulses are formed from the next value so they align with the first cycle gpio_in changes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      dcnt      <= '0;
      gpio_in   <= 1'b0;
      rise_pls  <= 1'b0;
      fall_pls  <= 1'b0;
    end else begin
      sync_meta <= pin;
      sync      <= sync_meta;
      dcnt      <= dcnt_nxt;
      gpio_in   <= gpio_nxt;
      rise_pls  <= gpio_nxt & ~gpio_in;
      fall_pls  <= ~gpio_nxt & gpio_in;
    end
  end

endmodule

// File: rtl/gpio_dflt_ctrl.sv
// GPIO input conditioning: shared sampling prescaler plus INNUM debounce channels.
module gpio_dflt_ctrl
  import gpio_dflt_ctrl_pkg::*;
#(
  parameter int unsigned INNUM = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [INNUM-1:0] pin_in,
  input  logic [CNTW-1:0]  refclk_st,
  input  logic [CNTW-1:0]  dflt_st,
  output logic [INNUM-1:0] gpio_in,
  output logic [INNUM-1:0] rise_pls,
  output logic [INNUM-1:0] fall_pls,
  output logic             smp_tick
);

  logic [CNTW-1:0] pcnt;

  // >= rather than == so a lowered setting mid-count fires on the next clk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt     <= '0;
      smp_tick <= 1'b0;
    end else if (pcnt >= refclk_st) begin
      pcnt     <= '0;
      smp_tick <= 1'b1;
    end else begin
      pcnt     <= pcnt + CNTW'(1);
      smp_tick <= 1'b0;
    end
  end

  for (genvar i = 0; i < int'(INNUM); i++) begin : g_ch
    gpio_dflt_ch u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .pin      (pin_in[i]),
      .smp_tick (smp_tick),
      .dflt_st  (dflt_st),
      .gpio_in  (gpio_in[i]),
      .rise_pls (rise_pls[i]),
      .fall_pls (fall_pls[i])
    );
  end

endmodule

// File: tb/tb_gpio_dflt_ctrl.sv
// Directed self-checking bench for gpio_dflt_ctrl.
module tb_gpio_dflt_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] pin_in;
  logic [7:0]  refclk_st;
  logic [7:0]  dflt_st;
  logic [15:0] gpio_in;
  logic [15:0] rise_pls;
  logic [15:0] fall_pls;
  logic        smp_tick;

  int total = 0;
  int bad   = 0;

  gpio_dflt_ctrl #(.INNUM(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pin_in    (pin_in),
    .refclk_st (refclk_st),
    .dflt_st   (dflt_st),
    .gpio_in   (gpio_in),
    .rise_pls  (rise_pls),
    .fall_pls  (fall_pls),
    .smp_tick  (smp_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n clocks; sample 1 time unit after each rising edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tick();
    int budget;
    budget = 0;
    do begin
      tick(1);
      budget++;
    end while (smp_tick !== 1'b1 && budget < 300);
    if (smp_tick !== 1'b1) chk("wait_tick_timeout", 32'(smp_tick), 32'd1);
  endtask

  initial begin
    int budget;
    rst_n     = 1'b0;
    pin_in    = 16'hFFFF;
    refclk_st = 8'd3;
    dflt_st   = 8'd0;

    // 1: reset with all pins high
    tick(2);
    chk("rst_gpio", 32'(gpio_in), 32'h0);
    chk("rst_rise", 32'(rise_pls), 32'h0);
    chk("rst_tick", 32'(smp_tick), 32'h0);
    chk("rst_pcnt", 32'(dut.pcnt), 32'h0);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_gpio", 32'(gpio_in), 32'h0);
    chk("post_rst_rise", 32'(rise_pls), 32'h0);
    chk("post_rst_tick", 32'(smp_tick), 32'h0);
    tick(2);
    chk("rst_bypass_gpio", 32'(gpio_in), 32'hFFFF);
    chk("rst_bypass_rise", 32'(rise_pls), 32'hFFFF);
    pin_in = 16'h0000;
    tick(5);
    chk("clear_gpio", 32'(gpio_in), 32'h0);

    // 2: bypass latency and glitch pass-through
    pin_in[3] = 1'b1;
    tick(2);
    chk("byp_k2_gpio", 32'(gpio_in), 32'h0);
    tick(1);
    chk("byp_k3_gpio", 32'(gpio_in), 32'h0008);
    chk("byp_k3_rise", 32'(rise_pls), 32'h0008);
    tick(1);
    chk("byp_k4_rise", 32'(rise_pls), 32'h0);
    pin_in[5] = 1'b1;
    tick(1);
    pin_in[5] = 1'b0;
    tick(2);
    chk("glitch_gpio_hi", 32'(gpio_in), 32'h0028);
    chk("glitch_rise", 32'(rise_pls), 32'h0020);
    tick(1);
    chk("glitch_gpio_lo", 32'(gpio_in), 32'h0008);
    chk("glitch_fall", 32'(fall_pls), 32'h0020);
    pin_in = 16'h0000;
    tick(4);
    chk("clear2_gpio", 32'(gpio_in), 32'h0);

    // 3: prescaler period and mid-count decrease
    wait_tick();
    tick(3);
    chk("psc3_gap", 32'(smp_tick), 32'h0);
    tick(1);
    chk("psc3_tick", 32'(smp_tick), 32'h1);
    refclk_st = 8'd9;
    tick(5);
    chk("psc9_pcnt5", 32'(dut.pcnt), 32'd5);
    chk("psc9_notick", 32'(smp_tick), 32'h0);
    refclk_st = 8'd2;
    tick(1);
    chk("psc_dec_tick", 32'(smp_tick), 32'h1);
    tick(2);
    chk("psc2_gap", 32'(smp_tick), 32'h0);
    tick(1);
    chk("psc2_tick", 32'(smp_tick), 32'h1);

    // 4: tick every clk, threshold 3
    refclk_st = 8'd0;
    dflt_st   = 8'd3;
    tick(2);
    pin_in[0] = 1'b1;
    tick(2);
    pin_in[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("flt_short_gpio", 32'(gpio_in[0]), 32'h0);
      chk("flt_short_rise", 32'(rise_pls[0]), 32'h0);
      tick(1);
    end
    pin_in[0] = 1'b1;
    tick(4);
    chk("flt_hold_pre", 32'(gpio_in), 32'h0);
    tick(1);
    chk("flt_hold_gpio", 32'(gpio_in), 32'h0001);
    chk("flt_hold_rise", 32'(rise_pls), 32'h0001);
    tick(1);
    chk("flt_hold_rise_once", 32'(rise_pls), 32'h0);
    pin_in[0] = 1'b0;
    tick(4);
    chk("flt_drop_pre", 32'(gpio_in), 32'h0001);
    tick(1);
    chk("flt_drop_gpio", 32'(gpio_in), 32'h0);
    chk("flt_drop_fall", 32'(fall_pls), 32'h0001);

    // 5: tick every 5 clk, threshold 2, low blip restarts the count
    refclk_st = 8'd4;
    dflt_st   = 8'd2;
    wait_tick();
    wait_tick();
    pin_in[1] = 1'b1;
    tick(8);
    pin_in[1] = 1'b0;
    tick(1);
    pin_in[1] = 1'b1;
    tick(2);
    chk("blip_t2_gpio", 32'(gpio_in), 32'h0);
    tick(5);
    chk("blip_t3_gpio", 32'(gpio_in), 32'h0);
    tick(5);
    chk("blip_t4_gpio", 32'(gpio_in), 32'h0002);
    chk("blip_t4_rise", 32'(rise_pls), 32'h0002);

    // 6: reset mid-filter, then bypass
    refclk_st = 8'd0;
    dflt_st   = 8'd200;
    pin_in[2] = 1'b1;
    budget = 0;
    while (dut.g_ch[2].u_ch.dcnt != 8'd50 && budget < 400) begin
      tick(1);
      budget++;
    end
    chk("mid_dcnt50", 32'(dut.g_ch[2].u_ch.dcnt), 32'd50);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("mid_rst_dcnt", 32'(dut.g_ch[2].u_ch.dcnt), 32'd0);
    chk("mid_rst_gpio", 32'(gpio_in), 32'h0);
    chk("mid_rst_fall", 32'(fall_pls), 32'h0);
    dflt_st = 8'd0;
    tick(2);
    chk("mid_byp_pre", 32'(gpio_in), 32'h0);
    tick(1);
    chk("mid_byp_gpio", 32'(gpio_in), 32'h0006);
    chk("mid_byp_rise", 32'(rise_pls), 32'h0006);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_dflt_ctrl.md
Name: gpio_dflt_ctrl

Overview:
Input-conditioning controller for the GPIO peripheral. It sits between the raw input pins and the GPIO register block, and is configured by that block's dflt_st and refclk_st outputs. It synchronises the pins, generates a programmable sampling tick, and runs a per-pin debounce filter. It drives the filtered gpio_in vector that the register block reads, and emits one-cycle edge pulses for later interrupt logic.

Parameters:
INNUM, 16, number of input pins / filter channels
CNTW, 8, width of the prescaler and of each channel's debounce counter (fixed, equal to the config width)

Ports:
clk  in  1  global clock
rst_n  in  1  global reset, synchronous, active-low
pin_in  in  INNUM  raw asynchronous pin levels
refclk_st  in  8  prescaler setting N; sample tick every N+1 clk
dflt_st  in  8  filter threshold T in ticks; 0 = bypass
gpio_in  out  INNUM  filtered, registered pin levels (to register block)
rise_pls  out  INNUM  one-cycle pulse on filtered 0->1
fall_pls  out  INNUM  one-cycle pulse on filtered 1->0
smp_tick  out  1  sampling tick, one clk wide (debug / shared)

Behaviour:
- Single clock domain. Reset is synchronous and active-low: all state is cleared on a clk edge with rst_n=0.
- Reset values: gpio_in=0, rise_pls=0, fall_pls=0, smp_tick=0; synchroniser FFs, prescaler count and all channel counters = 0.
- Synchroniser: 2-FF per bit, pin_in -> sync[i]. No reset-dependent glitch: after reset, sync reflects pins within 2 clk.
- Prescaler: 8-bit count pcnt.
  - If pcnt >= refclk_st: smp_tick=1 (registered) and pcnt<=0; else pcnt<=pcnt+1, smp_tick=0.
  - N=0 gives a tick every clk; N=255 gives a tick every 256 clk.
  - The >= compare handles a mid-count decrease of refclk_st: the tick fires on the next clk.
- Channel filter (per bit i, counter dcnt[i]):
  - Bypass (dflt_st==0): gpio_in[i] <= sync[i] every clk; dcnt[i] <= 0. Pin-to-gpio_in latency is 3 clk.
  - Filter (dflt_st!=0), evaluated only on clk where smp_tick=1:
    - sync[i]==gpio_in[i] -> dcnt[i] <= 0.
    - else if dcnt[i]+1 >= dflt_st -> gpio_in[i] <= sync[i], dcnt[i] <= 0.
    - else dcnt[i] <= dcnt[i]+1.
  - Consequence: a new level must be seen on T consecutive ticks to be accepted. Any tick showing the old level restarts the count.
  - No tick -> dcnt and gpio_in hold.
  - dflt_st lowered mid-count below dcnt+1: the level is accepted on the next mismatching tick.
  - Switching to bypass clears dcnt on the next clk.
  - Switching from bypass to filter starts with dcnt=0.
  - dcnt saturates naturally: it never exceeds dflt_st-1 <= 254, so there is no wrap.
- Edge pulses: gpio_in_d registered copy.
  - rise_pls = gpio_in & ~gpio_in_d; fall_pls = ~gpio_in & gpio_in_d.
  - Each pulse is high exactly one clk, on the first clk gpio_in shows the new level.
  - Reset forces gpio_in_d=0, so no pulse follows reset.
- Channels are independent. Simultaneous toggles on several bits produce simultaneous pulses.
- Reset mid-filter: all counts are lost and gpio_in returns to 0. This applies even if pins are high; the pin is re-accepted by normal filtering (or after 3 clk in bypass).

Decomposition:
- Shared header (alongside core_general.vh): DFLT_BYPASS=8'h00 and CNTW=8.
- One natural sub-module, gpio_dflt_ch: one bit's synchroniser, debounce counter, output and edge registers. Inputs are smp_tick and dflt_st. It is instantiated INNUM times by generate.
- The prescaler stays in the top.

Test Plan:
1. Reset with pin_in=16'hFFFF held -> during reset and 1 clk after: gpio_in=0, rise_pls=0, smp_tick=0, pcnt=0.
2. dflt_st=0, pin_in[3] 0->1 at clk k -> gpio_in[3]=1 at clk k+3. rise_pls[3]=1 only at k+3; a 1-clk glitch on pin_in[5] appears on gpio_in[5] as 1 clk high.
3. refclk_st=3 -> smp_tick high every 4th clk. Set refclk_st=9, wait until pcnt=5, then write refclk_st=2 -> tick on the next clk, then every 3 clk.
4. refclk_st=0, dflt_st=3: a pin_in[0] pulse of 2 clk -> gpio_in[0] stays 0, no rise_pls. A held high -> gpio_in[0]=1 exactly 3 ticks after sync[0] rises, with one rise_pls[0]. A later drop held -> fall_pls[0] after 3 ticks.
5. refclk_st=4, dflt_st=2, pin_in[1] high: low blip on one tick between the two accepting ticks -> acceptance is delayed by the restart, and gpio_in[1] rises only after two further consecutive high ticks.
6. dflt_st=200 with dcnt[2]=50 mid-filter: assert rst_n=0 for 1 clk -> dcnt=0, gpio_in[2]=0, no fall_pls. Then set dflt_st=0 -> gpio_in[2] follows sync within 1 clk.
